// File: rtl/move_selector.sv
// move_selector: cursor, turn and move-count controller feeding the cell-enable decoder.
// Optional MOVE_SELECTOR_SKIP_OCCUPIED_EN makes the cursor hop over occupied cells.
module move_selector #(
    parameter int NUM_CELLS = 9,
    parameter int SEL_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_next,
    input  logic                 btn_place,
    input  logic [NUM_CELLS-1:0] occupied,
    input  logic                 game_over,
    output logic [SEL_W-1:0]     sel,
    output logic                 place,
    output logic                 player,
    output logic                 reject,
    output logic [SEL_W-1:0]     move_cnt,
    output logic                 locked
);
    typedef enum logic [1:0] {SELECT, VALIDATE, COMMIT, LOCKED} state_t;
    state_t state, state_d;
    logic btn_next_q, btn_place_q, rise_next, rise_place;
    logic place_d, player_d, reject_d;
    logic [SEL_W-1:0] sel_d, cnt_d, sel_adv, sel_after;
    assign rise_next  = btn_next & ~btn_next_q;
    assign rise_place = btn_place & ~btn_place_q;
`ifdef MOVE_SELECTOR_SKIP_OCCUPIED_EN
    function automatic logic [SEL_W-1:0] next_free(input logic [SEL_W-1:0] s, input logic [NUM_CELLS-1:0] occ);
        logic [SEL_W-1:0] r;
        r = s;
        for (int k = NUM_CELLS - 1; k >= 1; k--)
            if (!occ[(int'(s) + k) % NUM_CELLS]) r = SEL_W'((int'(s) + k) % NUM_CELLS);
        return r;
    endfunction
    assign sel_adv   = next_free(sel, occupied);
    // the cell just written may not show in occupied yet, so mask it in
    assign sel_after = next_free(sel, occupied | (NUM_CELLS'(1) << sel));
`else
    assign sel_adv   = (sel == SEL_W'(NUM_CELLS - 1)) ? '0 : sel + 1'b1;
    assign sel_after = sel;
`endif
    always_comb begin
        state_d  = state;
        sel_d    = sel;
        cnt_d    = move_cnt;
        player_d = player;
        place_d  = 1'b0;
        reject_d = 1'b0;
        case (state)
            SELECT: begin
                if (game_over) state_d = LOCKED;
                else if (rise_place) state_d = VALIDATE;
                else if (rise_next) sel_d = sel_adv;
            end
            VALIDATE: begin
                reject_d = occupied[sel];
                place_d  = ~occupied[sel];
                state_d  = occupied[sel] ? SELECT : COMMIT;
            end
            COMMIT: begin
                player_d = ~player;
                cnt_d    = move_cnt + 1'b1;
                state_d  = (move_cnt == SEL_W'(NUM_CELLS - 1)) ? LOCKED : SELECT;
                sel_d    = (move_cnt == SEL_W'(NUM_CELLS - 1)) ? sel : sel_after;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SELECT;
            btn_next_q  <= 1'b1;
            btn_place_q <= 1'b1;
            sel         <= '0;
            place       <= 1'b0;
            player      <= 1'b0;
            reject      <= 1'b0;
            move_cnt    <= '0;
            locked      <= 1'b0;
        end else begin
            state       <= state_d;
            btn_next_q  <= btn_next;
            btn_place_q <= btn_place;
            sel         <= sel_d;
            place       <= place_d;
            player      <= player_d;
            reject      <= reject_d;
            move_cnt    <= cnt_d;
            locked      <= (state_d == LOCKED);
        end
    end
endmodule

// File: tb/tb_move_selector.sv
// tb_move_selector: directed self-checking bench for move_selector.
module tb_move_selector;
    logic clk = 1'b0, rst_n, btn_next, btn_place, game_over;
    logic [8:0] occupied;
    logic [3:0] sel, move_cnt;
    logic place, player, reject, locked;
    int n_cmp = 0, n_bad = 0;
    int sel_m, cnt_m;
    logic pl_m, lock_m;
    logic [8:0] occ_m;

    move_selector dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_place(btn_place),
        .occupied(occupied), .game_over(game_over), .sel(sel), .place(place),
        .player(player), .reject(reject), .move_cnt(move_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

`ifdef MOVE_SELECTOR_SKIP_OCCUPIED_EN
    function automatic int skip_next(input int s, input logic [8:0] occ);
        int r;
        bit found;
        r = s;
        found = 0;
        for (int k = 1; k <= 8; k++)
            if (!found && !occ[(s + k) % 9]) begin
                r = (s + k) % 9;
                found = 1;
            end
        return r;
    endfunction
`endif

    task automatic press_next();
        btn_next = 1'b1;
        tick();
        btn_next = 1'b0;
        tick();
        if (!lock_m) begin
`ifdef MOVE_SELECTOR_SKIP_OCCUPIED_EN
            sel_m = skip_next(sel_m, occupied);
`else
            sel_m = (sel_m == 8) ? 0 : sel_m + 1;
`endif
        end
        chk("next_sel", sel, sel_m);
    endtask

    task automatic goto_cell(input int t);
        for (int i = 0; i < 9 && sel_m != t; i++) press_next();
        chk("goto_sel", sel, t);
    endtask

    task automatic do_place(input bit exp_place, input bit exp_reject, input bit with_next);
        btn_place = 1'b1;
        btn_next  = with_next;
        tick();
        chk("place_early", place, 0);
        chk("sel_frozen", sel, sel_m);
        btn_place = 1'b0;
        btn_next  = 1'b0;
        tick();
        chk("place_pulse", place, exp_place);
        chk("reject_pulse", reject, exp_reject);
        chk("sel_at_place", sel, sel_m);
        chk("player_at_place", player, pl_m);
        tick();
        if (exp_place) begin
            pl_m = ~pl_m;
            cnt_m++;
            occ_m[sel_m] = 1'b1;
            if (cnt_m == 9) lock_m = 1'b1;
`ifdef MOVE_SELECTOR_SKIP_OCCUPIED_EN
            if (!lock_m) sel_m = skip_next(sel_m, occ_m);
`endif
        end
        occupied = occ_m;
        chk("place_end", place, 0);
        chk("reject_end", reject, 0);
        chk("player_after", player, pl_m);
        chk("cnt_after", move_cnt, cnt_m);
        chk("locked_after", locked, lock_m);
        chk("sel_after", sel, sel_m);
    endtask

    task automatic commit_free();
        int c;
        c = 0;
        while (c < 8 && occ_m[c]) c++;
        goto_cell(c);
        do_place(1, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_place", place, 0);
        chk("rst_player", player, 0);
        chk("rst_reject", reject, 0);
        chk("rst_cnt", move_cnt, 0);
        chk("rst_locked", locked, 0);
        tick();
        rst_n = 1'b1;
        sel_m = 0; cnt_m = 0; pl_m = 0; lock_m = 0; occ_m = '0;
        occupied = '0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; btn_next = 0; btn_place = 0; game_over = 0; occupied = '0;
        sel_m = 0; cnt_m = 0; pl_m = 0; lock_m = 0; occ_m = '0;
        repeat (2) tick();
        do_reset();
        // cursor walk including wrap
        for (int i = 0; i < 10; i++) begin
            press_next();
            chk("walk_no_place", place, 0);
        end
        goto_cell(4);
        do_place(1, 0, 0);
        goto_cell(2);
        occupied = occ_m | 9'b000000100;
        do_place(0, 1, 0);
        goto_cell(0);
        do_place(1, 0, 1);
        for (int c = 0; c < 9; c++)
            if (!occ_m[c]) begin
                goto_cell(c);
                do_place(1, 0, 0);
            end
        chk("full_cnt", move_cnt, 9);
        chk("full_locked", locked, 1);
        press_next();
        do_place(0, 0, 0);
        // game_over lock after five moves
        do_reset();
        repeat (5) commit_free();
        chk("go_pre_locked", locked, 0);
        game_over = 1'b1;
        tick();
        chk("go_locked", locked, 1);
        lock_m = 1'b1;
        game_over = 1'b0;
        press_next();
        do_place(0, 0, 0);
        chk("go_cnt", move_cnt, 5);
        // reset while in VALIDATE
        do_reset();
        press_next();
        btn_place = 1'b1;
        tick();
        rst_n = 1'b0;
        btn_place = 1'b0;
        #1;
        chk("midrst_sel", sel, 0);
        chk("midrst_place", place, 0);
        chk("midrst_locked", locked, 0);
        tick();
        chk("midrst_place2", place, 0);
        btn_next = 1'b1;
        rst_n = 1'b1;
        sel_m = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_place", place, 0);
            chk("held_btn_sel", sel, 0);
        end
        btn_next = 1'b0;
        tick();
`ifdef MOVE_SELECTOR_SKIP_OCCUPIED_EN
        do_reset();
        occupied = 9'b000001110;
        press_next();
        chk("skip_sel4", sel, 4);
        occupied = 9'b111111110;
        press_next();
        chk("skip_sel0", sel, 0);
        press_next();
        chk("skip_stay0", sel, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/move_selector.md
# move_selector

Cursor and turn controller that sits directly upstream of the 9-way cell-enable decoder in the tic-tac-toe datapath. Converts two player buttons (next, place) into a registered cell index `sel` (0..8), a one-cycle `place` commit strobe, and the current player. Checks the chosen cell against board occupancy before committing. Counts moves and locks when the board is full or the game is over.

## Interface
Parameters:
- `NUM_CELLS`, 9: number of board cells; `sel` wraps at `NUM_CELLS-1`.
- `SEL_W`, 4: width of `sel` and `move_cnt`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_next`  in  1  level input, already debounced and synchronised; each rising edge advances the cursor.
- `btn_place`  in  1  level input, already debounced and synchronised; each rising edge requests placement at `sel`.
- `occupied`  in  9  bit i is high when cell i holds a mark.
- `game_over`  in  1  level input from win detection; forces lock.
- `sel`  out  SEL_W  registered cursor index, 0..8; drives the decoder select.
- `place`  out  1  one-cycle commit strobe; qualifies the decoder enables.
- `player`  out  1  0 = X, 1 = O; the mark to write while `place` is high.
- `reject`  out  1  one-cycle pulse when a place request hits an occupied cell.
- `move_cnt`  out  SEL_W  committed moves, 0..9.
- `locked`  out  1  high in LOCKED state.

## Operation
- Edge detect: `btn_*_q` registers hold the previous sample. A rise is `btn & ~btn_q`. Both registers reset to 1, so a button held through reset produces no edge.
- State machine: SELECT, VALIDATE, COMMIT, LOCKED. All outputs are registered.
- SELECT:
  - `game_over` high -> LOCKED.
  - Else a place rise -> VALIDATE, with `sel` frozen.
  - Else a next rise -> `sel` advances: 8 wraps to 0, otherwise +1.
- VALIDATE, 1 cycle:
  - `occupied[sel]` high -> `reject` pulses for 1 cycle, then return to SELECT.
  - Otherwise -> COMMIT.
- COMMIT, 1 cycle:
  - `place` = 1, with `sel` and `player` stable.
  - On exit: `player` toggles and `move_cnt` increments.
  - If `move_cnt` becomes 9 -> LOCKED; else -> SELECT.
- LOCKED: all button edges ignored, `sel` and `player` held, `locked` = 1. Exits only on reset.
- Simultaneous events:
  - Place rise and next rise in the same SELECT cycle: place wins, next is dropped.
  - `game_over` together with either rise: `game_over` wins.
  - Rises during VALIDATE or COMMIT are dropped, not queued.
- Reset mid-operation (any state): immediate return to reset values. No `place` pulse may be emitted after `rst_n` falls.

## Timing
- Reset values: `sel`=0, `place`=0, `player`=0, `reject`=0, `move_cnt`=0, `locked`=0, state SELECT.
- Cursor latency: `sel` updates 1 cycle after the edge where the `btn_next` rise is sampled.
- Place latency: `place` (or `reject`) is high in the cycle beginning 2 clock edges after the `btn_place` rise is sampled.
- `place` width: exactly 1 cycle. `player` toggles on the edge ending the `place` cycle.
- Minimum spacing between commits: 3 cycles (SELECT, VALIDATE, COMMIT).
- `locked` rises 1 cycle after `game_over` is sampled in SELECT, or on the edge ending the 9th COMMIT.

## Configuration
- `MOVE_SELECTOR_SKIP_OCCUPIED_EN` defined:
  - A next rise moves `sel` to the nearest higher unoccupied index modulo 9, searching combinationally up to 8 steps. If every other cell is occupied, `sel` is unchanged.
  - After each COMMIT that does not lock, `sel` likewise moves to the next unoccupied cell.
- Undefined: plain +1 wrap on next rise; `sel` is unchanged after COMMIT.

## Test plan
- Reset release, then 10 next rises -> `sel` steps 1..8, 0, 1; `place` never asserts.
- `sel`=4, `occupied`=0, place rise -> `place` high for 1 cycle, 2 cycles after the rise, with `sel`=4 and `player`=0; afterwards `player`=1 and `move_cnt`=1.
- `sel`=2, `occupied`=9'b000000100, place rise -> `reject` pulse; no `place`; `player` and `move_cnt` unchanged.
- Place rise and next rise in the same cycle at `sel`=0 -> commit at cell 0; `sel` stays 0.
- 9 valid commits -> `move_cnt`=9 and `locked`=1; further rises ignored. Separately, assert `game_over` after 5 moves -> `locked`=1 one cycle later. Drop `rst_n` while in VALIDATE -> all outputs at reset values and no `place` pulse.
- With `MOVE_SELECTOR_SKIP_OCCUPIED_EN`, `occupied`=9'b000001110 and `sel`=0, next rise -> `sel`=4. With all cells except 0 occupied, next rise -> `sel` stays 0.
